mul_div_unit: RTL and testbench

//  Multi-cycle 16-bit unsigned multiply/divide unit in the RISC datapath execute stage.

---
 rtl/mul_div_unit_if.sv | 31 +++
 rtl/mul_div_unit.sv | 144 ++++++++++++++
 tb/tb_mul_div_unit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// Handshake and result bundle between the control unit and mul_div_unit.
// The control unit drives requests (master); the unit returns status and results (slave).
interface mul_div_unit_if #(
  parameter int WIDTH = 16
);
  logic             START;
  logic             OP;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BUSY;
  logic             DONE;
  logic             DIV0;
  logic             LD_LO;
  logic             LD_HI;
  logic [WIDTH-1:0] DOUT_LO;
  logic [WIDTH-1:0] DOUT_HI;

  modport master (
    output START, OP, A, B,
    input  BUSY, DONE, DIV0,
    input  LD_LO, LD_HI,
    input  DOUT_LO, DOUT_HI
  );

  modport slave (
    input  START, OP, A, B,
    output BUSY, DONE, DIV0,
    output LD_LO, LD_HI,
    output DOUT_LO, DOUT_HI
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply (shift-add) / restoring divide.
// One result bit per cycle; results land in a register pair via load strobes.
module mul_div_unit #(
  parameter int WIDTH = 16
) (
  input logic          CLK,
  input logic          RST_N,
  mul_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {
    IDLE,
    CALC
  } state_t;

  state_t           st_q, st_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] dlo_q, dlo_d;
  logic [WIDTH-1:0] dhi_q, dhi_d;

  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] it_hi;
  logic [WIDTH-1:0] it_lo;

  // One iteration step; hi/lo hold {acc,multiplier} or {rem,quot}.
  always_comb begin
    msum  = {1'b0, hi_q};
    sh    = {hi_q, lo_q[WIDTH-1]};
    trial = sh - {1'b0, b_q};
    it_hi = hi_q;
    it_lo = lo_q;
    if (lo_q[0]) begin
      msum = {1'b0, hi_q} + {1'b0, a_q};
    end
    if (!op_q) begin
      it_hi = msum[WIDTH:1];
      it_lo = {msum[0], lo_q[WIDTH-1:1]};
    end else if (!trial[WIDTH]) begin
      it_hi = trial[WIDTH-1:0];
      it_lo = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      it_hi = sh[WIDTH-1:0];
      it_lo = {lo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    busy_d = busy_q;
    done_d = 1'b0;
    dz_d   = 1'b0;
    dlo_d  = dlo_q;
    dhi_d  = dhi_q;
    unique case (st_q)
      IDLE: begin
        if (bus.START) begin
          op_d  = bus.OP;
          a_d   = bus.A;
          b_d   = bus.B;
          cnt_d = '0;
          if (bus.OP && (bus.B == '0)) begin
            dlo_d  = '1;
            dhi_d  = bus.A;
            done_d = 1'b1;
            dz_d   = 1'b1;
          end else begin
            hi_d   = '0;
            lo_d   = bus.OP ? bus.A : bus.B;
            busy_d = 1'b1;
            st_d   = CALC;
          end
        end
      end
      CALC: begin
        hi_d  = it_hi;
        lo_d  = it_lo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          dlo_d  = it_lo;
          dhi_d  = it_hi;
          done_d = 1'b1;
          busy_d = 1'b0;
          st_d   = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      op_q   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      dlo_q  <= '0;
      dhi_q  <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      busy_q <= busy_d;
      done_q <= done_d;
      dz_q   <= dz_d;
      dlo_q  <= dlo_d;
      dhi_q  <= dhi_d;
    end
  end

  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;
  assign bus.DIV0    = dz_q;
  assign bus.LD_LO   = done_q;
  assign bus.LD_HI   = done_q;
  assign bus.DOUT_LO = dlo_q;
  assign bus.DOUT_HI = dhi_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed ops, expected results queued,
// monitor pops and compares on every DONE.
module tb_mul_div_unit;
  logic CLK;
  logic RST_N;

  mul_div_unit_if #(.WIDTH(16)) bus ();

  mul_div_unit #(.WIDTH(16)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic        dz;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (RST_N && bus.DONE) begin
      done_seen++;
      chk("ld_strobes", {30'd0, bus.LD_LO, bus.LD_HI}, 32'd3);
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got DONE expected none");
      end else begin
        e = q.pop_front();
        chk("dout", {bus.DOUT_HI, bus.DOUT_LO}, {e.hi, e.lo});
        chk("div0", {31'd0, bus.DIV0}, {31'd0, e.dz});
      end
    end else if (RST_N) begin
      chk("idle_strobes",
          {29'd0, bus.LD_LO, bus.LD_HI, bus.DIV0}, 32'd0);
    end
  end

  task automatic push(input logic [15:0] lo, input logic [15:0] hi,
                      input logic dz);
    exp_t e;
    e.lo = lo;
    e.hi = hi;
    e.dz = dz;
    q.push_back(e);
  endtask

  task automatic start_op(input logic op, input logic [15:0] a,
                          input logic [15:0] b);
    bus.START = 1'b1;
    bus.OP    = op;
    bus.A     = a;
    bus.B     = b;
    @(posedge CLK);
    #1;
    bus.START = 1'b0;
  endtask

  task automatic wait_done(input string name, input int lat);
    int n;
    n = 0;
    while (!bus.DONE && n < 40) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk(name, n, lat);
  endtask

  initial begin
    int seen0;
    RST_N     = 1'b0;
    bus.START = 1'b0;
    bus.OP    = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_outs",
        {27'd0, bus.BUSY, bus.DONE, bus.DIV0, bus.LD_LO, bus.LD_HI}, 0);
    chk("reset_dout", {bus.DOUT_HI, bus.DOUT_LO}, 0);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;

    push(16'h0060, 16'h0626, 1'b0);
    start_op(1'b0, 16'h1234, 16'h5678);
    chk("t1_busy", {31'd0, bus.BUSY}, 1);
    wait_done("t1_latency", 16);
    chk("t1_busy_done", {31'd0, bus.BUSY}, 0);
    @(posedge CLK);
    #1;
    chk("t1_done_pulse", {31'd0, bus.DONE}, 0);

    push(16'h0001, 16'hFFFE, 1'b0);
    start_op(1'b0, 16'hFFFF, 16'hFFFF);
    wait_done("t2_latency", 16);

    push(16'h2492, 16'h0001, 1'b0);
    start_op(1'b1, 16'hFFFF, 16'h0007);
    wait_done("t3_latency", 16);
    repeat (4) @(posedge CLK);
    #1;
    chk("hold_dout", {bus.DOUT_HI, bus.DOUT_LO}, 32'h00012492);

    push(16'hFFFF, 16'h1234, 1'b1);
    start_op(1'b1, 16'h1234, 16'h0000);
    chk("t4_busy", {31'd0, bus.BUSY}, 0);
    wait_done("t4_latency", 0);
    @(posedge CLK);
    #1;
    chk("t4_busy_after", {31'd0, bus.BUSY}, 0);

    push(16'h0000, 16'h0000, 1'b0);
    start_op(1'b0, 16'h0000, 16'hABCD);
    wait_done("mul0_latency", 16);

    push(16'hFFFF, 16'h0000, 1'b0);
    start_op(1'b0, 16'h00FF, 16'h0101);
    repeat (4) @(posedge CLK);
    #1;
    start_op(1'b1, 16'h1111, 16'h0000);
    chk("t5_busy_ignored", {31'd0, bus.BUSY}, 1);
    wait_done("t5_latency", 11);
    push(16'h000E, 16'h0002, 1'b0);
    start_op(1'b1, 16'h0064, 16'h0007);
    chk("t5_b2b_busy", {31'd0, bus.BUSY}, 1);
    wait_done("t5_b2b_latency", 16);

    push(16'h0000, 16'h0003, 1'b0);
    start_op(1'b1, 16'h0003, 16'h0009);
    wait_done("div_small_latency", 16);

    start_op(1'b0, 16'h1234, 16'h5678);
    repeat (5) @(posedge CLK);
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    chk("t6_busy", {31'd0, bus.BUSY}, 0);
    chk("t6_done", {31'd0, bus.DONE}, 0);
    chk("t6_dout", {bus.DOUT_HI, bus.DOUT_LO}, 0);
    RST_N = 1'b1;
    seen0 = done_seen;
    repeat (20) @(posedge CLK);
    #1;
    chk("t6_no_done", done_seen - seen0, 0);
    chk("t6_idle_busy", {31'd0, bus.BUSY}, 0);

    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
